// File: rtl/multiword_shift_l_pkg.sv
// Shared types for the multiword left shifter: the shift mode selector
// and the sequencing FSM states.
package multiword_shift_l_pkg;

    typedef enum logic [1:0] {
        SHIFT_LOGIC = 2'd0,
        SHIFT_ARITH = 2'd1,
        SHIFT_RCL   = 2'd2,
        SHIFT_ROL   = 2'd3
    } shift_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

endpackage

// File: rtl/polyshift_l.sv
// Single-word left shifter: logical/arithmetic shift, rotate through a
// (word_width-1)-bit carry field, or plain rotate.
module polyshift_l
    import multiword_shift_l_pkg::*;
#(
    parameter int word_width = 8
) (
    input  shift_type_t                     shift_type,
    input  logic [$clog2(word_width)-1:0]   shift_size,
    input  logic [word_width-1:0]           d_in,
    input  logic [word_width-2:0]           c_in,
    output logic [word_width-1:0]           d_out
);

    localparam int size_width = $clog2(word_width);
    localparam logic [size_width-1:0] max_size = size_width'(word_width - 1);

    logic [word_width-1:0] shl;
    logic [word_width-1:0] fill;
    logic [word_width-1:0] rot_hi;

    // The low shift_size bits are refilled from the top of c_in (RCL) or the
    // top of d_in (ROL); the extra >>1 keeps the shift amount below word_width.
    always_comb begin
        shl    = d_in << shift_size;
        fill   = {1'b0, c_in} >> (max_size - shift_size);
        rot_hi = (d_in >> 1) >> (max_size - shift_size);
        d_out  = shl;
        case (shift_type)
            SHIFT_LOGIC, SHIFT_ARITH: d_out = shl;
            SHIFT_RCL:                d_out = shl | fill;
            default:                  d_out = shl | rot_hi;
        endcase
    end

endmodule

// File: rtl/multiword_shift_l.sv
// Streams an N-word operand (least-significant word first) through a
// single-word shifter, chaining the bits shifted out of each word into the next.
module multiword_shift_l
    import multiword_shift_l_pkg::*;
#(
    parameter int word_width  = 8,
    parameter int count_width = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  shift_type_t                     shift_type,
    input  logic [$clog2(word_width)-1:0]   shift_size,
    input  logic [count_width-1:0]          word_count,
    input  logic [word_width-2:0]           carry_in,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [word_width-1:0]           in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [word_width-1:0]           out_data,
    output logic                            out_last,
    output logic [word_width-2:0]           carry_out,
    output logic                            busy,
    output state_t                          dbg_state
);

    // Handshakes: a word moves on any rising edge where valid && ready. A source
    // holds valid and data stable until accepted; ready may depend on the
    // sink's own state and on downstream ready, never on the source's valid.

    state_t                         state;
    shift_type_t                    cfg_type;
    logic [$clog2(word_width)-1:0]  cfg_size;
    logic [count_width-1:0]         cfg_n;
    logic [count_width-1:0]         cnt;
    logic [word_width-2:0]          chain;
    logic [word_width-1:0]          first_word;
    logic [word_width-1:0]          shift_d_in;
    logic [word_width-1:0]          shift_result;
    logic                           out_free;
    logic                           in_fire;
    logic                           is_last;

    assign out_free   = !out_valid || out_ready;
    assign in_ready   = (state == ST_RUN) && out_free;
    assign in_fire    = in_valid && in_ready;
    assign is_last    = (cnt == cfg_n - count_width'(1));
    assign shift_d_in = (state == ST_TAIL) ? first_word : in_data;
    assign busy       = (state != ST_IDLE);
    assign dbg_state  = state;

    polyshift_l #(
        .word_width (word_width)
    ) u_shift (
        .shift_type (SHIFT_RCL),
        .shift_size (cfg_size),
        .d_in       (shift_d_in),
        .c_in       (chain),
        .d_out      (shift_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cfg_type   <= SHIFT_LOGIC;
            cfg_size   <= '0;
            cfg_n      <= '0;
            cnt        <= '0;
            chain      <= '0;
            first_word <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            carry_out  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start && word_count != '0) begin
                        cfg_type <= shift_type;
                        cfg_size <= shift_size;
                        cfg_n    <= word_count;
                        cnt      <= '0;
                        // Left arithmetic shift across words equals logical.
                        chain    <= (shift_type == SHIFT_RCL) ? carry_in : '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_fire) begin
                        cnt   <= cnt + count_width'(1);
                        chain <= in_data[word_width-1:1];
                        // A rotate needs the top word's bits for word 0, so
                        // word 0 is parked and emitted last from TAIL.
                        if (cfg_type == SHIFT_ROL && cnt == '0) begin
                            first_word <= in_data;
                        end else begin
                            out_data  <= shift_result;
                            out_valid <= 1'b1;
                            out_last  <= is_last && (cfg_type != SHIFT_ROL);
                        end
                        if (is_last) begin
                            if (cfg_type == SHIFT_ROL) begin
                                state <= ST_TAIL;
                            end else begin
                                carry_out <= in_data[word_width-1:1];
                                state     <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_TAIL: begin
                    if (out_free) begin
                        out_data  <= shift_result;
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        carry_out <= chain;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_shift_l.sv
// Directed bench for multiword_shift_l at word_width=8, count_width=8.
module tb_multiword_shift_l;
    import multiword_shift_l_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    shift_type_t shift_type;
    logic [2:0]  shift_size;
    logic [7:0]  word_count;
    logic [6:0]  carry_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [6:0]  carry_out;
    logic        busy;
    state_t      dbg_state;

    int total = 0;
    int bad = 0;

    // Each observed beat is {out_last, out_data}.
    logic [8:0] got_q[$];
    logic       busy_q[$];

    multiword_shift_l #(.word_width(8), .count_width(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .shift_type (shift_type),
        .shift_size (shift_size),
        .word_count (word_count),
        .carry_in   (carry_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .carry_out  (carry_out),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back({out_last, out_data});
            busy_q.push_back(busy);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input shift_type_t t, input logic [2:0] s,
                            input logic [7:0] n, input logic [6:0] c);
        @(posedge clk); #1;
        start = 1'b1; shift_type = t; shift_size = s; word_count = n; carry_in = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] w, output bit acc);
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = w;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit done);
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b want=0", out_last); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h want=00", out_data); end
        total++; if (carry_out !== 7'h00) begin bad++; $display("FAIL rst_carry_out got=%h want=00", carry_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_logic();
        logic [8:0] exp_q[$];
        bit ok, f;
        got_q.delete(); busy_q.delete();
        ok = 1'b1;
        do_start(SHIFT_LOGIC, 3'd4, 8'd2, 7'h00);
        feed(8'h12, f); ok &= f;
        feed(8'h34, f); ok &= f;
        wait_idle(f); ok &= f;
        exp_q = '{9'h020, 9'h141};
        total++; if (!ok) begin bad++; $display("FAIL logic_timeout got=stalled want=complete"); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL logic_beats got=%0d want=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL logic_beat%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1FF, exp_q[i]);
            end
        end
        total++; if (carry_out !== 7'h1A) begin bad++; $display("FAIL logic_carry got=%h want=1a", carry_out); end
    endtask

    task automatic test_rcl();
        bit ok, f;
        got_q.delete(); busy_q.delete();
        ok = 1'b1;
        do_start(SHIFT_RCL, 3'd3, 8'd1, 7'h7F);
        feed(8'h01, f); ok &= f;
        wait_idle(f); ok &= f;
        total++; if (!ok) begin bad++; $display("FAIL rcl_timeout got=stalled want=complete"); end
        total++; if (got_q.size() != 1 || got_q[0] !== 9'h10F) begin
            bad++; $display("FAIL rcl_beat got=%0d beats first=%h want=1 beat 10f", got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h000);
        end
        total++; if (carry_out !== 7'h00) begin bad++; $display("FAIL rcl_carry got=%h want=00", carry_out); end
    endtask

    task automatic test_rol();
        logic [8:0] exp_q[$];
        bit ok, f;
        got_q.delete(); busy_q.delete();
        ok = 1'b1;
        do_start(SHIFT_ROL, 3'd4, 8'd2, 7'h00);
        feed(8'h12, f); ok &= f;
        // Word 0 is held back, so nothing may be presented yet.
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rol_hold got=%b want=0", out_valid); end
        feed(8'h34, f); ok &= f;
        wait_idle(f); ok &= f;
        exp_q = '{9'h041, 9'h123};
        total++; if (!ok) begin bad++; $display("FAIL rol_timeout got=stalled want=complete"); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rol_beats got=%0d want=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rol_beat%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1FF, exp_q[i]);
            end
        end
        total++; if (busy_q.size() != 2 || busy_q[1] !== 1'b0) begin bad++; $display("FAIL rol_busy_at_last got=%0d entries want=2 with busy 0", busy_q.size()); end
    endtask

    task automatic test_modes_misc();
        logic [8:0] exp_q[$];
        bit ok, f;
        // ROL with a single word, then shift 0 rotate, then ARITH.
        got_q.delete(); busy_q.delete();
        ok = 1'b1;
        do_start(SHIFT_ROL, 3'd3, 8'd1, 7'h00);
        feed(8'h81, f); ok &= f;
        wait_idle(f); ok &= f;
        do_start(SHIFT_ROL, 3'd0, 8'd3, 7'h55);
        feed(8'h5A, f); ok &= f;
        feed(8'hC3, f); ok &= f;
        feed(8'h0F, f); ok &= f;
        wait_idle(f); ok &= f;
        do_start(SHIFT_ARITH, 3'd2, 8'd1, 7'h7F);
        feed(8'hF0, f); ok &= f;
        wait_idle(f); ok &= f;
        exp_q = '{9'h10C, 9'h0C3, 9'h00F, 9'h15A, 9'h1C0};
        total++; if (!ok) begin bad++; $display("FAIL misc_timeout got=stalled want=complete"); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL misc_beats got=%0d want=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL misc_beat%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1FF, exp_q[i]);
            end
        end
        total++; if (carry_out !== 7'h78) begin bad++; $display("FAIL arith_carry got=%h want=78", carry_out); end
    endtask

    task automatic test_backpressure();
        logic [8:0] exp_q[$];
        bit ok, f;
        got_q.delete(); busy_q.delete();
        ok = 1'b1;
        do_start(SHIFT_LOGIC, 3'd1, 8'd3, 7'h00);
        feed(8'h81, f); ok &= f;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h42;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h02 || out_last !== 1'b0 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got=v%b d%h l%b r%b want=v1 d02 l0 r0", c, out_valid, out_data, out_last, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        feed(8'h42, f); ok &= f;
        feed(8'hC3, f); ok &= f;
        wait_idle(f); ok &= f;
        exp_q = '{9'h002, 9'h085, 9'h186};
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=stalled want=complete"); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_beats got=%0d want=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1FF, exp_q[i]);
            end
        end
        total++; if (carry_out !== 7'h61) begin bad++; $display("FAIL bp_carry got=%h want=61", carry_out); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] exp_q[$];
        bit ok, f;
        got_q.delete(); busy_q.delete();
        ok = 1'b1;
        do_start(SHIFT_LOGIC, 3'd2, 8'd4, 7'h00);
        feed(8'h11, f); ok &= f;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (got_q.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stray got=%0d beats v%b want=0 beats v0", got_q.size(), out_valid); end
        do_start(SHIFT_LOGIC, 3'd2, 8'd2, 7'h00);
        feed(8'hC1, f); ok &= f;
        feed(8'h22, f); ok &= f;
        wait_idle(f); ok &= f;
        exp_q = '{9'h004, 9'h18B};
        total++; if (!ok) begin bad++; $display("FAIL midrst_timeout got=stalled want=complete"); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_beats got=%0d want=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL midrst_beat%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1FF, exp_q[i]);
            end
        end
        total++; if (carry_out !== 7'h11) begin bad++; $display("FAIL midrst_carry got=%h want=11", carry_out); end
    endtask

    task automatic test_ignored_start();
        logic [8:0] exp_q[$];
        bit ok, f;
        got_q.delete(); busy_q.delete();
        ok = 1'b1;
        do_start(SHIFT_LOGIC, 3'd1, 8'd0, 7'h00);
        @(negedge clk);
        total++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin bad++; $display("FAIL zero_count got=busy%b st%0d want=busy0 st0", busy, dbg_state); end
        do_start(SHIFT_RCL, 3'd3, 8'd2, 7'h7F);
        feed(8'hA5, f); ok &= f;
        // Attempt to reconfigure mid-operation.
        start = 1'b1; shift_type = SHIFT_LOGIC; shift_size = 3'd0; word_count = 8'd1; carry_in = 7'h00;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_start got=busy%b want=busy1", busy); end
        feed(8'h3C, f); ok &= f;
        wait_idle(f); ok &= f;
        exp_q = '{9'h02F, 9'h1E5};
        total++; if (!ok) begin bad++; $display("FAIL ign_timeout got=stalled want=complete"); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ign_beats got=%0d want=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL ign_beat%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 9'h1FF, exp_q[i]);
            end
        end
        total++; if (carry_out !== 7'h1E) begin bad++; $display("FAIL ign_carry got=%h want=1e", carry_out); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        shift_type = SHIFT_LOGIC;
        shift_size = 3'd0;
        word_count = 8'd0;
        carry_in = 7'h00;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        test_reset();
        test_logic();
        test_rcl();
        test_rol();
        test_modes_misc();
        test_backpressure();
        test_reset_mid();
        test_ignored_start();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
